// File: rtl/impulse_capture_pkg.sv
// impulse_capture_pkg: shared capture states, sample width and magnitude helper
package impulse_capture_pkg;
  localparam int SAMPLE_W = 18;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_e;
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] y);
    return (y == {1'b1, {(SAMPLE_W-1){1'b0}}}) ? {1'b0, {(SAMPLE_W-1){1'b1}}} : (y[SAMPLE_W-1] ? -y : y);
  endfunction
endpackage

// File: rtl/impulse_capture_if.sv
// impulse_capture_if: sample input and valid/ready readback port of the capture block
interface impulse_capture_if import impulse_capture_pkg::*; #(parameter int WIDTH = SAMPLE_W);
  logic sam_clk_en;
  logic signed [WIDTH-1:0] y_in;
  logic rd_ready;
  logic rd_valid;
  logic signed [WIDTH-1:0] rd_data;
  logic rd_last;
  modport master (output sam_clk_en, y_in, rd_ready, input rd_valid, rd_data, rd_last);
  modport slave (input sam_clk_en, y_in, rd_ready, output rd_valid, rd_data, rd_last);
endinterface

// File: rtl/capture_buf.sv
// capture_buf: register array with one synchronous write port and an asynchronous read port
module capture_buf #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // storage has no reset; contents are only read after being written by a capture
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/impulse_capture.sv
// impulse_capture: threshold-triggered window capture of y with peak tracking and valid/ready readback
module impulse_capture import impulse_capture_pkg::*; #(
  parameter int WIDTH  = SAMPLE_W,
  parameter int DEPTH  = 64,
  parameter int THRESH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  impulse_capture_if.slave         io,
  input  logic                     arm,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         peak_mag,
  output logic [$clog2(DEPTH)-1:0] peak_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] TH = WIDTH'(THRESH);
  state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, peak_idx_q, peak_idx_d, waddr;
  logic [WIDTH-1:0] peak_mag_q, peak_mag_d, mag;
  logic done_q, done_d, we;
  assign mag = abs_sat(io.y_in);
  // next state, buffer write and peak tracking; abort overrides every transition
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    peak_mag_d = peak_mag_q;
    peak_idx_d = peak_idx_q;
    done_d = 1'b0;
    we = 1'b0;
    waddr = (state_q == ARMED) ? '0 : wr_ptr_q;
    case (state_q)
      IDLE: if (arm) begin
        state_d = ARMED;
        peak_mag_d = '0;
        peak_idx_d = '0;
      end
      ARMED: if (io.sam_clk_en && mag >= TH) begin
        we = 1'b1;
        wr_ptr_d = AW'(1);
        peak_mag_d = mag;
        peak_idx_d = '0;
        state_d = CAPTURE;
      end
      CAPTURE: if (io.sam_clk_en) begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        peak_mag_d = (mag > peak_mag_q) ? mag : peak_mag_q;
        peak_idx_d = (mag > peak_mag_q) ? wr_ptr_q : peak_idx_q;
        state_d = (wr_ptr_q == LAST) ? READOUT : CAPTURE;
      end
      READOUT: if (io.rd_ready) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        done_d = (rd_ptr_q == LAST);
        state_d = (rd_ptr_q == LAST) ? IDLE : READOUT;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      peak_mag_d = peak_mag_q;
      peak_idx_d = peak_idx_q;
      done_d = 1'b0;
      we = 1'b0;
    end
  end
  // state, pointer and peak registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      peak_mag_q <= peak_mag_d;
      peak_idx_q <= peak_idx_d;
      done_q <= done_d;
    end
  capture_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(io.y_in),
    .raddr(rd_ptr_q),
    .rdata(io.rd_data)
  );
  assign io.rd_valid = (state_q == READOUT);
  assign io.rd_last = (state_q == READOUT) && (rd_ptr_q == LAST);
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign peak_mag = peak_mag_q;
  assign peak_idx = peak_idx_q;
endmodule

// File: tb/tb_impulse_capture.sv
// tb_impulse_capture: randomized scenario bench for impulse_capture against a window/peak reference model
module tb_impulse_capture;
  localparam int DEPTH = 64;
  logic clk = 1'b0, reset = 1'b0, arm = 1'b0, abort = 1'b0, sel = 1'b0;
  logic sam_clk_en = 1'b0, rd_ready = 1'b0;
  logic signed [17:0] y_in = '0;
  logic busy1, done1, busy2, done2;
  logic [17:0] peak1, peak2;
  logic [5:0] idx1, idx2;
  logic o_valid, o_last, o_busy, o_done;
  logic signed [17:0] o_data;
  logic [17:0] o_peak;
  logic [5:0] o_idx;
  int total = 0, bad = 0;
  int fed[$];
  int impulse_got[$];

  always #5 clk = ~clk;

  impulse_capture_if if1();
  impulse_capture_if if2();
  assign if1.sam_clk_en = sam_clk_en;
  assign if1.y_in = y_in;
  assign if1.rd_ready = rd_ready;
  assign if2.sam_clk_en = sam_clk_en;
  assign if2.y_in = y_in;
  assign if2.rd_ready = rd_ready;

  impulse_capture #(.DEPTH(DEPTH), .THRESH(1)) dut (
    .clk(clk), .reset(reset), .io(if1), .arm(arm & ~sel), .abort(abort),
    .busy(busy1), .done(done1), .peak_mag(peak1), .peak_idx(idx1));
  impulse_capture #(.DEPTH(DEPTH), .THRESH(100)) dut_th (
    .clk(clk), .reset(reset), .io(if2), .arm(arm & sel), .abort(abort),
    .busy(busy2), .done(done2), .peak_mag(peak2), .peak_idx(idx2));

  assign o_valid = sel ? if2.rd_valid : if1.rd_valid;
  assign o_last = sel ? if2.rd_last : if1.rd_last;
  assign o_data = sel ? if2.rd_data : if1.rd_data;
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;
  assign o_peak = sel ? peak2 : peak1;
  assign o_idx = sel ? idx2 : idx1;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int th, output int win[$], output int pk, output int pi);
    bit trig = 0;
    win.delete();
    pk = 0;
    pi = 0;
    foreach (fed[i]) begin
      int m = fed[i] < 0 ? -fed[i] : fed[i];
      if (m > 131071) m = 131071;
      if (m >= th) trig = 1;
      if (trig && win.size() < DEPTH) begin
        if (win.size() == 0 || m > pk) begin
          pk = m;
          pi = win.size();
        end
        win.push_back(fed[i]);
      end
    end
  endtask

  task automatic arm_pulse;
    arm = 1'b1;
    fed.delete();
    step();
    arm = 1'b0;
  endtask

  task automatic feed(input int v, input int gap);
    y_in = 18'(v);
    sam_clk_en = 1'b1;
    fed.push_back(v);
    step();
    sam_clk_en = 1'b0;
    y_in = 18'($urandom);
    repeat (gap) step();
  endtask

  task automatic readout(input bit stall, input int stop_at, input int base, output int got[$]);
    int cyc = 0, dones = 0, hd = 0;
    bit held = 0;
    logic hl = 1'b0;
    got.delete();
    while (got.size() < stop_at && cyc < 4000) begin
      rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        total++;
        if (int'(o_data) !== hd || o_last !== hl || o_valid !== 1'b1) begin
          bad++;
          $display("FAIL stall_hold: data=%0d last=%0b valid=%0b, want data=%0d last=%0b valid=1", o_data, o_last, o_valid, hd, hl);
        end
      end
      held = 0;
      if (o_valid && rd_ready) begin
        total++;
        if (o_last !== (base + got.size() == DEPTH - 1)) begin
          bad++;
          $display("FAIL rd_last at transfer %0d: got %0b", base + got.size(), o_last);
        end
        got.push_back(int'(o_data));
      end else if (o_valid) begin
        held = 1;
        hd = int'(o_data);
        hl = o_last;
      end
      step();
      cyc++;
      if (o_done) dones++;
    end
    rd_ready = 1'b0;
    if (base + stop_at == DEPTH) begin
      total++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || dones != 1) begin
        bad++;
        $display("FAIL readout_end: done=%0b busy=%0b valid=%0b dones=%0d, want 1 0 0 1", o_done, o_busy, o_valid, dones);
      end
      step();
      total++;
      if (o_done !== 1'b0) begin
        bad++;
        $display("FAIL done_pulse_width: done=%0b, want 0", o_done);
      end
    end
  endtask

  task automatic run_capture(input string nm, input int smp[$], input int gap, input bit stall, input int th, output int got[$]);
    int win[$];
    int pk, pi;
    arm_pulse();
    total++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s armed: busy=%0b valid=%0b, want 1 0", nm, o_busy, o_valid);
    end
    foreach (smp[i]) begin
      model(th, win, pk, pi);
      total++;
      if (o_valid !== (win.size() == DEPTH)) begin
        bad++;
        $display("FAIL %s valid_timing before sample %0d: valid=%0b", nm, i, o_valid);
      end
      feed(smp[i], gap < 0 ? $urandom_range(0, 3) : gap);
    end
    model(th, win, pk, pi);
    total++;
    if (o_valid !== 1'b1 || win.size() != DEPTH) begin
      bad++;
      $display("FAIL %s readout_start: valid=%0b window=%0d, want 1 %0d", nm, o_valid, win.size(), DEPTH);
    end
    readout(stall, DEPTH, 0, got);
    total++;
    if (got.size() != DEPTH) begin
      bad++;
      $display("FAIL %s transfers: got %0d want %0d", nm, got.size(), DEPTH);
    end
    foreach (win[i]) begin
      total++;
      if (i >= got.size() || got[i] != win[i]) begin
        bad++;
        $display("FAIL %s data[%0d]: got %0d want %0d", nm, i, i < got.size() ? got[i] : 0, win[i]);
      end
    end
    total++;
    if (o_peak !== 18'(pk) || o_idx !== 6'(pi)) begin
      bad++;
      $display("FAIL %s peak: got mag=%0d idx=%0d want mag=%0d idx=%0d", nm, o_peak, o_idx, pk, pi);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) step();
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || if1.rd_valid !== 1'b0 || if1.rd_last !== 1'b0 || peak1 !== '0 || idx1 !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%0b done=%0b valid=%0b last=%0b peak=%0d idx=%0d, want all 0", busy1, done1, if1.rd_valid, if1.rd_last, peak1, idx1);
    end
    reset = 1'b1;
    step();
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release busy: got %0b want 0", busy1);
    end
  endtask

  task automatic test_impulse;
    int smp[$] = '{0, 0, 0, 65536};
    for (int k = 0; k < 63; k++) smp.push_back(32768 >> k);
    run_capture("impulse", smp, 3, 0, 1, impulse_got);
    total++;
    if (impulse_got.size() == 0 || impulse_got[0] != 65536 || o_peak !== 18'd65536 || o_idx !== 6'd0) begin
      bad++;
      $display("FAIL impulse_values: buf0=%0d peak=%0d idx=%0d want 65536 65536 0", impulse_got.size() ? impulse_got[0] : 0, o_peak, o_idx);
    end
  endtask

  task automatic test_negative_fullscale;
    int smp[$] = '{-131072};
    int got[$];
    repeat (63) smp.push_back(0);
    run_capture("neg_fs", smp, -1, 0, 1, got);
    total++;
    if (got.size() == 0 || got[0] != -131072 || o_peak !== 18'd131071 || o_idx !== 6'd0) begin
      bad++;
      $display("FAIL neg_fs_values: buf0=%0d peak=%0d idx=%0d want -131072 131071 0", got.size() ? got[0] : 0, o_peak, o_idx);
    end
  endtask

  task automatic test_threshold;
    int smp[$] = '{99, 100, 500, -500, 20};
    int got[$];
    repeat (60) smp.push_back(0);
    sel = 1'b1;
    run_capture("threshold", smp, 1, 0, 100, got);
    total++;
    if (got.size() < 3 || got[0] != 100 || got[1] != 500 || got[2] != -500 || o_peak !== 18'd500 || o_idx !== 6'd1) begin
      bad++;
      $display("FAIL threshold_values: buf0=%0d peak=%0d idx=%0d want 100 500 1", got.size() ? got[0] : 0, o_peak, o_idx);
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure;
    int smp[$] = '{0, 0, 0, 65536};
    int got[$];
    for (int k = 0; k < 63; k++) smp.push_back(32768 >> k);
    run_capture("backpressure", smp, 3, 1, 1, got);
    foreach (impulse_got[i]) begin
      total++;
      if (i >= got.size() || got[i] != impulse_got[i]) begin
        bad++;
        $display("FAIL backpressure_vs_unstalled[%0d]: got %0d want %0d", i, i < got.size() ? got[i] : 0, impulse_got[i]);
      end
    end
  endtask

  task automatic test_abort;
    int win[$];
    int pk, pi;
    arm_pulse();
    feed(1000, 1);
    repeat (9) feed(int'($urandom_range(0, 262143)) - 131072, 1);
    model(1, win, pk, pi);
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (busy1 !== 1'b0 || if1.rd_valid !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: busy=%0b valid=%0b done=%0b want 0 0 0", busy1, if1.rd_valid, done1);
    end
    total++;
    if (peak1 !== 18'(pk) || idx1 !== 6'(pi)) begin
      bad++;
      $display("FAIL abort_peak_kept: mag=%0d idx=%0d want %0d %0d", peak1, idx1, pk, pi);
    end
    for (int i = 0; i < 6; i++) begin
      feed(int'($urandom_range(0, 262143)) - 131072, 0);
      total++;
      if (if1.rd_valid !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet cycle %0d: valid=%0b done=%0b busy=%0b", i, if1.rd_valid, done1, busy1);
      end
    end
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL arm_abort_same_cycle: busy=%0b want 0", busy1);
    end
  endtask

  task automatic test_reset_mid;
    int smp[$] = '{7777};
    int got[$];
    repeat (63) smp.push_back(int'($urandom_range(0, 262143)) - 131072);
    arm_pulse();
    foreach (smp[i]) feed(smp[i], 0);
    readout(0, 30, 0, got);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b0 || if1.rd_valid !== 1'b0 || if1.rd_last !== 1'b0 || done1 !== 1'b0 || peak1 !== '0 || idx1 !== '0) begin
      bad++;
      $display("FAIL async_reset: busy=%0b valid=%0b last=%0b done=%0b peak=%0d idx=%0d want all 0", busy1, if1.rd_valid, if1.rd_last, done1, peak1, idx1);
    end
    step();
    reset = 1'b1;
    step();
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%0b want 0", busy1);
    end
    smp.delete();
    repeat (64) smp.push_back(int'($urandom_range(1, 131071)));
    run_capture("after_reset", smp, 1, 0, 1, got);
  endtask

  task automatic test_arm_busy;
    int win[$], g1[$], g2[$];
    int pk, pi;
    arm_pulse();
    for (int i = 0; i < 64; i++) begin
      arm = (i == 20);
      feed(int'($urandom_range(0, 262143)) - 131072 | 1, 1);
    end
    arm = 1'b0;
    readout(0, 20, 0, g1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    total++;
    if (busy1 !== 1'b1 || if1.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL arm_in_readout: busy=%0b valid=%0b want 1 1", busy1, if1.rd_valid);
    end
    readout(0, 44, 20, g2);
    model(1, win, pk, pi);
    foreach (win[i]) begin
      total++;
      if ((i < 20 ? (i < g1.size() ? g1[i] : 0) : (i - 20 < g2.size() ? g2[i-20] : 0)) != win[i]) begin
        bad++;
        $display("FAIL arm_busy data[%0d]: want %0d", i, win[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (busy1 !== 1'b0) begin
        bad++;
        $display("FAIL arm_not_queued cycle %0d: busy=%0b want 0", i, busy1);
      end
    end
  endtask

  task automatic test_random;
    int got[$];
    for (int r = 0; r < 4; r++) begin
      int smp[$];
      repeat ($urandom_range(0, 5)) smp.push_back(0);
      repeat (64 + $urandom_range(0, 6)) smp.push_back(int'($urandom_range(0, 262143)) - 131072);
      run_capture("random", smp, -1, 1'($urandom_range(0, 1)), 1, got);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_negative_fullscale();
    test_threshold();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_arm_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/impulse_capture.md
Name: impulse_capture

Overview:
- Output-side counterpart to the sample-file stimulus path: observes the filter output `y` at the sample rate and arms on request.
- Triggers on the first sample whose magnitude reaches a threshold, then captures a fixed-length window into an on-chip buffer.
- Streams the captured window out over a valid/ready read port and reports the peak magnitude and its index.
- Used to read back impulse responses of the filter chain in hardware and in simulation.

Parameters:
- WIDTH, 18, sample width (signed, matches `y`).
- DEPTH, 64, number of samples captured per trigger; power of two, at least 2.
- THRESH, 1, trigger magnitude (unsigned, compared against saturated |y|).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; all state clears while reset==0.
- sam_clk_en  in  1  sample-rate enable; `y_in` is valid only when this is high.
- y_in  in  WIDTH  signed filter output sample.
- arm  in  1  one-cycle request to start a capture; honoured only in IDLE.
- abort  in  1  returns to IDLE from any state on the next edge; buffer contents are kept.
- rd_ready  in  1  consumer ready.
- rd_valid  out  1  read data valid.
- rd_data  out  WIDTH  captured sample at the read pointer.
- rd_last  out  1  high with the final sample (index DEPTH-1).
- busy  out  1  high in ARMED, CAPTURE and READOUT.
- done  out  1  one-cycle pulse after the last read transfer.
- peak_mag  out  WIDTH  maximum saturated |y| in the last window.
- peak_idx  out  clog2(DEPTH)  index of the first occurrence of peak_mag.

Behaviour:
- Reset values: state=IDLE, all pointers 0, rd_valid=0, rd_last=0, busy=0, done=0, peak_mag=0, peak_idx=0. Buffer contents are don't-care.
- Magnitude: mag = (y_in<0) ? -y_in : y_in, computed in WIDTH+1 bits and saturated to 2^(WIDTH-1)-1. For example, -131072 gives 131071.
- IDLE:
  - arm=1 moves to ARMED next edge.
  - peak_mag and peak_idx are cleared on that same edge.
- ARMED:
  - On sam_clk_en with mag>=THRESH, the sample is written to buf[0], wr_ptr becomes 1, and the state moves to CAPTURE.
  - The trigger sample is index 0; the peak is initialised to (mag, 0).
  - Samples while sam_clk_en=0 are ignored.
- CAPTURE:
  - Each sam_clk_en writes y_in to buf[wr_ptr], then increments wr_ptr.
  - Peak updates only when mag > peak_mag (strict), so the earliest index wins.
  - When the write at index DEPTH-1 occurs, the state moves to READOUT on that edge. wr_ptr wraps to 0 and is unused afterwards.
  - No samples are dropped or duplicated.
- READOUT:
  - rd_valid=1 and rd_data=buf[rd_ptr] (combinational read of the register array).
  - rd_last=(rd_ptr==DEPTH-1).
  - A transfer occurs when rd_valid & rd_ready; rd_ptr then increments.
  - rd_data, rd_last and rd_ptr hold stable while rd_ready=0; there is no timeout.
  - On the transfer with rd_last=1: move to IDLE, rd_ptr returns to 0, done=1 for exactly one cycle.
  - sam_clk_en and y_in are ignored throughout READOUT.
- arm in any state other than IDLE is ignored (no queuing).
- abort has priority over every other transition, including a simultaneous trigger, final write or last transfer.
  - On abort: next state is IDLE, rd_valid drops and done stays 0.
  - peak_mag and peak_idx keep their partial values.
- arm and abort in the same cycle while in IDLE: abort wins and the state stays IDLE.
- Reset asserted mid-operation clears immediately (asynchronously). After release the block is in IDLE and needs a fresh arm.
- busy = (state!=IDLE), registered-state derived; it has no combinational path from the inputs.
- Latency:
  - Trigger sample to rd_valid: DEPTH-1 sam_clk_en events, plus one clk edge.
  - Readout throughput: one sample per clk while rd_ready=1.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ARMED, CAPTURE, READOUT);
  - the sample WIDTH constant (18), shared with the filter top level;
  - an abs_sat function (WIDTH in, WIDTH out).
- One sub-module, capture_buf: a DEPTH x WIDTH register array with a single synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). It has no reset.

Test Plan:
- Impulse: arm, then drive 0,0,0,+65536 followed by a filter-like decay 32768,16384,... on sam_clk_en every 4th clk, with rd_ready=1 → 64 transfers, buf[0]=65536, peak_mag=65536, peak_idx=0, rd_last only on transfer 64, done pulses once, busy drops on the same edge.
- Negative full-scale: trigger sample -131072 followed by zeros → peak_mag=131071, rd_data[0]=-131072 (raw), peak_idx=0.
- Tie and threshold: THRESH=100; samples 99 (ignored), then 100, 500, -500, 20 → trigger at 100, peak_mag=500, peak_idx=1 (first occurrence).
- Backpressure: toggle rd_ready pseudo-randomly during READOUT → data sequence identical to the unstalled run, rd_data stable while stalled, exactly 64 transfers.
- Abort and reset: abort in CAPTURE after 10 writes → IDLE next edge, no rd_valid, no done. Separately, pull reset low during READOUT at rd_ptr=30 → all outputs reset immediately, and arm after release restarts in ARMED.
- Arm while busy: pulse arm during CAPTURE and during READOUT → no effect; exactly one capture/readout cycle completes.
